// File: rtl/demo_trigger.sv
// rtl/demo_trigger.sv - debounced push-button burst sequencer for the demo master control port
// Conditions btn/sw_mode, then issues BURST start/mode requests paced on ready.
module demo_trigger #(
    parameter int DB_WIDTH        = 16,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int BURST           = 4,
    parameter int ACK_TIMEOUT     = 4,
    parameter int CNT_WIDTH       = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 btn,
    input  logic                 sw_mode,
    input  logic                 ready,
    output logic                 start,
    output logic                 mode,
    output logic                 busy,
    output logic                 err,
    output logic [CNT_WIDTH-1:0] txn_count
);

    localparam int REM_W = 4;
    localparam int TO_W  = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        WAIT_DONE
    } state_t;

    state_t               state_q, state_d;
    logic                 btn_m_q, btn_m_d;
    logic                 btn_s_q, btn_s_d;
    logic                 sw_m_q, sw_m_d;
    logic                 sw_s_q, sw_s_d;
    logic                 btn_db_q, btn_db_d;
    logic                 btn_db_prev_q, btn_db_prev_d;
    logic [DB_WIDTH-1:0]  db_cnt_q, db_cnt_d;
    logic [REM_W-1:0]     remaining_q, remaining_d;
    logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
    logic                 start_q, start_d;
    logic                 mode_q, mode_d;
    logic                 err_q, err_d;
    logic [CNT_WIDTH-1:0] txn_count_q, txn_count_d;
    logic                 press;

    always_comb begin
        btn_m_d       = btn;
        btn_s_d       = btn_m_q;
        sw_m_d        = sw_mode;
        sw_s_d        = sw_m_q;
        btn_db_d      = btn_db_q;
        db_cnt_d      = db_cnt_q;
        btn_db_prev_d = btn_db_q;
        // Any return to the accepted level restarts the stability window.
        if (btn_s_q == btn_db_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_WIDTH'(DEBOUNCE_CYCLES - 1)) begin
            btn_db_d = btn_s_q;
            db_cnt_d = '0;
        end else begin
            db_cnt_d = db_cnt_q + 1'b1;
        end
    end

    assign press = btn_db_q & ~btn_db_prev_q;

    always_comb begin
        state_d     = state_q;
        start_d     = 1'b0;
        mode_d      = mode_q;
        err_d       = err_q;
        remaining_d = remaining_q;
        to_cnt_d    = to_cnt_q;
        txn_count_d = txn_count_q;
        case (state_q)
            IDLE: begin
                if (press) begin
                    mode_d      = sw_s_q;
                    remaining_d = REM_W'(BURST);
                    err_d       = 1'b0;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (ready) begin
                    start_d  = 1'b1;
                    to_cnt_d = '0;
                    state_d  = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                // A master that never drops ready abandons the whole burst.
                if (!ready) begin
                    state_d = WAIT_DONE;
                end else if (to_cnt_q == TO_W'(ACK_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (ready) begin
                    txn_count_d = txn_count_q + 1'b1;
                    remaining_d = remaining_q - 1'b1;
                    state_d     = (remaining_q == REM_W'(1)) ? IDLE : ISSUE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= IDLE;
            btn_m_q       <= 1'b0;
            btn_s_q       <= 1'b0;
            sw_m_q        <= 1'b0;
            sw_s_q        <= 1'b0;
            btn_db_q      <= 1'b0;
            btn_db_prev_q <= 1'b0;
            db_cnt_q      <= '0;
            remaining_q   <= '0;
            to_cnt_q      <= '0;
            start_q       <= 1'b0;
            mode_q        <= 1'b0;
            err_q         <= 1'b0;
            txn_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            btn_m_q       <= btn_m_d;
            btn_s_q       <= btn_s_d;
            sw_m_q        <= sw_m_d;
            sw_s_q        <= sw_s_d;
            btn_db_q      <= btn_db_d;
            btn_db_prev_q <= btn_db_prev_d;
            db_cnt_q      <= db_cnt_d;
            remaining_q   <= remaining_d;
            to_cnt_q      <= to_cnt_d;
            start_q       <= start_d;
            mode_q        <= mode_d;
            err_q         <= err_d;
            txn_count_q   <= txn_count_d;
        end
    end

    assign start     = start_q;
    assign mode      = mode_q;
    assign busy      = (state_q != IDLE);
    assign err       = err_q;
    assign txn_count = txn_count_q;

endmodule

// File: tb/tb_demo_trigger.sv
// tb/tb_demo_trigger.sv - scoreboard bench for demo_trigger with a modelled demo master
// Stimulus pushes expected start/done/err events; a monitor pops them as the DUT produces them.
module tb_demo_trigger;

    localparam int BURST_N = 4;
    localparam int K_START = 0;
    localparam int K_DONE  = 1;
    localparam int K_ERR   = 2;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       btn = 1'b0;
    logic       sw_mode = 1'b0;
    logic       ready = 1'b1;
    logic       start, mode, busy, err;
    logic [7:0] txn_count;

    int         n_checks = 0;
    int         n_fail = 0;
    int         n_starts = 0;
    int         s0;
    bit         stuck = 1'b0;
    bit         force_low = 1'b0;
    logic [7:0] exp_cnt = 8'd0;

    typedef struct {
        int         kind;
        logic       m;
        logic [7:0] cnt;
        logic       last;
    } exp_t;
    exp_t sb[$];

    demo_trigger #(
        .DB_WIDTH(16), .DEBOUNCE_CYCLES(8), .BURST(BURST_N), .ACK_TIMEOUT(4), .CNT_WIDTH(8)
    ) dut (
        .clk(clk), .rstn(rstn), .btn(btn), .sw_mode(sw_mode), .ready(ready),
        .start(start), .mode(mode), .busy(busy), .err(err), .txn_count(txn_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_burst(input logic m);
        for (int i = 0; i < BURST_N; i++) begin
            sb.push_back('{K_START, m, exp_cnt, 1'b0});
            exp_cnt = exp_cnt + 8'd1;
            sb.push_back('{K_DONE, m, exp_cnt, (i == BURST_N - 1)});
        end
    endtask

    task automatic push_timeout(input logic m);
        sb.push_back('{K_START, m, exp_cnt, 1'b0});
        sb.push_back('{K_ERR, m, exp_cnt, 1'b1});
    endtask

    task automatic pop_check(input int kind);
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d expected no event at %0t", kind, $time);
        end else begin
            e = sb.pop_front();
            check("event_kind", kind, e.kind);
            if (kind == K_START) begin
                check("start_mode", mode, e.m);
                check("start_count", txn_count, e.cnt);
            end else if (kind == K_DONE) begin
                check("done_count", txn_count, e.cnt);
                check("done_busy", busy, !e.last);
            end else begin
                check("err_busy", busy, 1'b0);
                check("err_count", txn_count, e.cnt);
            end
        end
    endtask

    // Demo master: ready drops the cycle after start and returns 5 cycles later.
    initial begin
        int rcnt;
        rcnt = 0;
        forever begin
            @(negedge clk);
            if (!rstn) rcnt = 0;
            else if (rcnt > 0) rcnt--;
            else if (start && !stuck) rcnt = 6;
            ready = force_low ? 1'b0 : !(rcnt >= 1 && rcnt <= 5);
        end
    end

    initial begin
        logic       start_prev, err_prev;
        logic [7:0] cnt_prev;
        start_prev = 1'b0;
        err_prev   = 1'b0;
        cnt_prev   = 8'd0;
        forever begin
            @(negedge clk);
            if (rstn) begin
                if (start) begin
                    n_starts++;
                    check("start_width", start_prev, 1'b0);
                    pop_check(K_START);
                end
                if (txn_count != cnt_prev) pop_check(K_DONE);
                if (err && !err_prev) pop_check(K_ERR);
            end
            start_prev = start;
            err_prev   = err;
            cnt_prev   = txn_count;
        end
    end

    task automatic wait_busy(input int lim, input string nm);
        int k = 0;
        while (!busy && k < lim) begin @(negedge clk); k++; end
        check(nm, busy, 1'b1);
    endtask

    task automatic wait_idle(input int lim, input string nm);
        int k = 0;
        while (busy && k < lim) begin @(negedge clk); k++; end
        check(nm, busy, 1'b0);
    endtask

    task automatic wait_start(input int lim, input string nm);
        int k = 0;
        while (!start && k < lim) begin @(negedge clk); k++; end
        check(nm, start, 1'b1);
    endtask

    task automatic press_hold(input int n);
        btn = 1'b1;
        repeat (n) @(negedge clk);
        btn = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_start", start, 1'b0);
        check("rst_mode", mode, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_count", txn_count, 8'd0);
        rstn = 1'b1;

        // Bounce shorter than the debounce window is never accepted.
        for (int i = 0; i < 40; i++) begin
            btn = ((i / 3) % 2 == 0);
            @(negedge clk);
        end
        btn = 1'b0;
        repeat (30) @(negedge clk);
        check("bounce_starts", n_starts, 0);
        check("bounce_count", txn_count, 8'd0);
        check("bounce_busy", busy, 1'b0);

        // Clean write burst.
        sw_mode = 1'b1;
        repeat (3) @(negedge clk);
        push_burst(1'b1);
        press_hold(20);
        wait_idle(300, "burst_idle");
        check("burst_starts", n_starts, 4);
        check("burst_count", txn_count, 8'd4);
        check("burst_err", err, 1'b0);
        check("burst_sb_empty", sb.size(), 0);
        repeat (20) @(negedge clk);

        // Backpressure at the press, then a mid-burst mode switch toggle.
        sw_mode   = 1'b0;
        force_low = 1'b1;
        ready     = 1'b0;
        repeat (3) @(negedge clk);
        push_burst(1'b0);
        btn = 1'b1;
        wait_busy(40, "bp_busy");
        s0 = n_starts;
        repeat (10) @(negedge clk);
        check("bp_no_start", n_starts, s0);
        force_low = 1'b0;
        ready     = 1'b1;
        @(negedge clk);
        check("bp_start_latency", start, 1'b1);
        sw_mode = 1'b1;
        btn     = 1'b0;
        wait_idle(300, "bp_idle");
        check("bp_mode_locked", mode, 1'b0);
        check("bp_count", txn_count, 8'd8);
        check("bp_sb_empty", sb.size(), 0);
        repeat (20) @(negedge clk);

        // Ack timeout with ready stuck high; a second press clears err.
        stuck = 1'b1;
        repeat (3) @(negedge clk);
        push_timeout(1'b1);
        btn = 1'b1;
        wait_start(40, "to_start");
        repeat (3) @(negedge clk);
        check("to_err_early", err, 1'b0);
        @(negedge clk);
        check("to_err", err, 1'b1);
        check("to_busy", busy, 1'b0);
        check("to_count", txn_count, 8'd8);
        btn = 1'b0;
        repeat (20) @(negedge clk);
        push_timeout(1'b1);
        btn = 1'b1;
        wait_busy(40, "to2_busy");
        check("to2_err_cleared", err, 1'b0);
        wait_idle(40, "to2_idle");
        check("to2_err", err, 1'b1);
        btn = 1'b0;
        repeat (20) @(negedge clk);
        stuck = 1'b0;
        check("to_sb_empty", sb.size(), 0);

        // Counter wrap: 64 bursts from zero.
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        exp_cnt = 8'd0;
        sb.delete();
        repeat (3) @(negedge clk);
        for (int b = 0; b < 64; b++) begin
            push_burst(1'b1);
            press_hold(20);
            wait_idle(300, "wrap_idle");
            repeat (15) @(negedge clk);
        end
        check("wrap_count", txn_count, 8'd0);
        check("wrap_sb_empty", sb.size(), 0);

        // Reset during WAIT_DONE aborts the burst immediately.
        push_burst(1'b1);
        btn = 1'b1;
        wait_start(40, "mid_start");
        repeat (3) @(negedge clk);
        check("mid_busy", busy, 1'b1);
        rstn = 1'b0;
        #1;
        check("mid_rst_start", start, 1'b0);
        check("mid_rst_mode", mode, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_err", err, 1'b0);
        check("mid_rst_count", txn_count, 8'd0);
        sb.delete();
        exp_cnt = 8'd0;
        btn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        s0 = n_starts;
        repeat (40) @(negedge clk);
        check("post_rst_no_start", n_starts, s0);
        push_burst(1'b1);
        press_hold(20);
        wait_idle(300, "post_rst_idle");
        check("post_rst_count", txn_count, 8'd4);
        check("post_rst_sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
